// File: rtl/rf_seq_pkg.sv
// Shared types and sizes for the register-file maintenance sequencer.
package rf_seq_pkg;

    localparam int unsigned RF_ADDR_W = 6;
    localparam int unsigned RF_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_COPY  = 2'd1,
        OP_SWAP  = 2'd2,
        OP_CLEAR = 2'd3
    } rf_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE1 = 3'd2,
        ST_WRITE2 = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_DONE   = 3'd5
    } rf_seq_state_t;

endpackage

// File: rtl/register_file_sequencer.sv
// Command-driven initiator for the register file: LOAD, COPY, SWAP and
// CLEAR-range commands, one per valid/ready handshake. All outputs are
// flops loaded with the values that belong to the next state, so the
// register-file ports never see a combinational path from RfReadData*.
module register_file_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DataWidth = RF_DATA_W,
    parameter int unsigned AddrWidth = RF_ADDR_W
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [1:0]           CmdOp,
    input  logic [AddrWidth-1:0] CmdRegA,
    input  logic [AddrWidth-1:0] CmdRegB,
    input  logic [DataWidth-1:0] CmdImm,
    output logic                 Busy,
    output logic                 Done,
    output logic [AddrWidth-1:0] RfAddressA,
    output logic [AddrWidth-1:0] RfAddressB,
    output logic [DataWidth-1:0] RfWriteData,
    output logic                 RfWriteEnable,
    input  logic [DataWidth-1:0] RfReadDataA,
    input  logic [DataWidth-1:0] RfReadDataB
);

    rf_seq_state_t        state_q, state_d;
    rf_op_t               op_q, op_d;
    logic [AddrWidth-1:0] reg_a_q, reg_a_d;
    logic [AddrWidth-1:0] reg_b_q, reg_b_d;
    logic [DataWidth-1:0] hold_a_q, hold_a_d;
    logic [DataWidth-1:0] hold_b_q, hold_b_d;
    // One bit wider than an address so a range ending at the top register
    // cannot alias back to zero.
    logic [AddrWidth:0]   ptr_q, ptr_d;
    logic [AddrWidth:0]   ptr_next;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [AddrWidth-1:0] rf_addr_a_q, rf_addr_a_d;
    logic [AddrWidth-1:0] rf_addr_b_q, rf_addr_b_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
    logic                 rf_we_q, rf_we_d;

    assign ptr_next = ptr_q + 1'b1;

    // Next-state, captured command fields and next-cycle port values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        ptr_d       = ptr_q;
        rf_addr_a_d = '0;
        rf_addr_b_d = '0;
        rf_wdata_d  = '0;
        rf_we_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CmdValid) begin
                    op_d    = rf_op_t'(CmdOp);
                    reg_a_d = CmdRegA;
                    reg_b_d = CmdRegB;
                    case (rf_op_t'(CmdOp))
                        OP_LOAD: begin
                            state_d     = ST_WRITE1;
                            rf_addr_a_d = CmdRegA;
                            rf_wdata_d  = CmdImm;
                            rf_we_d     = 1'b1;
                        end
                        OP_COPY: begin
                            state_d     = ST_READ;
                            rf_addr_b_d = CmdRegB;
                        end
                        OP_SWAP: begin
                            state_d     = ST_READ;
                            rf_addr_a_d = CmdRegA;
                            rf_addr_b_d = CmdRegB;
                        end
                        default: begin
                            if (CmdRegA > CmdRegB) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d     = ST_CLEAR;
                                ptr_d       = {1'b0, CmdRegA};
                                rf_addr_a_d = CmdRegA;
                                rf_we_d     = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_READ: begin
                hold_b_d = RfReadDataB;
                if (op_q == OP_SWAP) begin
                    hold_a_d = RfReadDataA;
                end
                // The data flop is loaded alongside HoldB, so WRITE1 drives
                // the held value rather than a live read.
                state_d     = ST_WRITE1;
                rf_addr_a_d = reg_a_q;
                rf_wdata_d  = RfReadDataB;
                rf_we_d     = 1'b1;
            end
            ST_WRITE1: begin
                if (op_q == OP_SWAP) begin
                    state_d     = ST_WRITE2;
                    rf_addr_a_d = reg_b_q;
                    rf_wdata_d  = hold_a_q;
                    rf_we_d     = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE2: begin
                state_d = ST_DONE;
            end
            ST_CLEAR: begin
                if (ptr_q == {1'b0, reg_b_q}) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d       = ptr_next;
                    rf_addr_a_d = ptr_next[AddrWidth-1:0];
                    rf_we_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // FSM state, command/hold registers and registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            ptr_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_addr_a_q <= '0;
            rf_addr_b_q <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            ptr_q       <= ptr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_addr_a_q <= rf_addr_a_d;
            rf_addr_b_q <= rf_addr_b_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
        end
    end

    assign CmdReady      = cmd_ready_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign RfAddressA    = rf_addr_a_q;
    assign RfAddressB    = rf_addr_b_q;
    assign RfWriteData   = rf_wdata_q;
    assign RfWriteEnable = rf_we_q;

endmodule

// File: tb/tb_register_file_sequencer.sv
// Directed self-checking bench for register_file_sequencer with a
// behavioural 64 x 16 register file as responder.
module tb_register_file_sequencer;
    import rf_seq_pkg::*;

    logic        clk;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_reg_a;
    logic [5:0]  cmd_reg_b;
    logic [15:0] cmd_imm;
    logic        busy;
    logic        done;
    logic [5:0]  rf_addr_a;
    logic [5:0]  rf_addr_b;
    logic [15:0] rf_wdata;
    logic        rf_we;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;

    logic [15:0] rf_mem [0:63];

    int n_checks;
    int n_fail;
    logic [5:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int done_cyc;

    register_file_sequencer #(
        .DataWidth(16),
        .AddrWidth(6)
    ) dut (
        .Clock        (clk),
        .nReset       (n_reset),
        .CmdValid     (cmd_valid),
        .CmdReady     (cmd_ready),
        .CmdOp        (cmd_op),
        .CmdRegA      (cmd_reg_a),
        .CmdRegB      (cmd_reg_b),
        .CmdImm       (cmd_imm),
        .Busy         (busy),
        .Done         (done),
        .RfAddressA   (rf_addr_a),
        .RfAddressB   (rf_addr_b),
        .RfWriteData  (rf_wdata),
        .RfWriteEnable(rf_we),
        .RfReadDataA  (rf_rdata_a),
        .RfReadDataB  (rf_rdata_b)
    );

    // Register file responder: synchronous write, combinational reads.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr_a] <= rf_wdata;
    end
    assign rf_rdata_a = rf_mem[rf_addr_a];
    assign rf_rdata_b = rf_mem[rf_addr_b];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one command and watch it to completion; cycle k is the k-th
    // falling edge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                         input logic [15:0] imm, input bit hold_valid);
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1;
        @(negedge clk);
        check_eq("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg_a = a;
        cmd_reg_b = b;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        if (!hold_valid) cmd_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (rf_we) begin
                wr_addr.push_back(rf_addr_a);
                wr_data.push_back(rf_wdata);
            end
            if (done) begin
                done_cyc  = k;
                cmd_valid = 1'b0;
                break;
            end
            if (hold_valid) check_eq("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
        end
        if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] v);
        issue(OP_LOAD, a, 6'd0, v, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_reg_a = 6'd0;
        cmd_reg_b = 6'd0;
        cmd_imm   = 16'd0;
        repeat (3) @(negedge clk);

        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_we",    {31'd0, rf_we}, 32'd0);
        check_eq("rst_addr",  {20'd0, rf_addr_a, rf_addr_b}, 32'd0);
        check_eq("rst_wdata", {16'd0, rf_wdata}, 32'd0);
        n_reset = 1'b1;

        // LOAD r15 = F0F0
        issue(OP_LOAD, 6'd15, 6'd0, 16'hF0F0, 1'b0);
        check_eq("load_done_cyc", done_cyc, 32'd2);
        check_eq("load_we_cnt", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check_eq("load_addr", {26'd0, wr_addr[0]}, 32'd15);
            check_eq("load_data", {16'd0, wr_data[0]}, 32'h0000F0F0);
        end
        check_eq("load_r15", {16'd0, rf_mem[15]}, 32'h0000F0F0);

        // COPY r22 <- r3
        load(6'd3, 16'h1234);
        issue(OP_COPY, 6'd22, 6'd3, 16'hDEAD, 1'b0);
        check_eq("copy_done_cyc", done_cyc, 32'd3);
        check_eq("copy_we_cnt", wr_addr.size(), 32'd1);
        check_eq("copy_r22", {16'd0, rf_mem[22]}, 32'h00001234);
        check_eq("copy_r3",  {16'd0, rf_mem[3]},  32'h00001234);

        // COPY onto itself still writes once, value unchanged
        issue(OP_COPY, 6'd22, 6'd22, 16'h0, 1'b0);
        check_eq("copy_self_we_cnt", wr_addr.size(), 32'd1);
        check_eq("copy_self_r22", {16'd0, rf_mem[22]}, 32'h00001234);

        // SWAP r5, r6
        load(6'd5, 16'hAAAA);
        load(6'd6, 16'h5555);
        issue(OP_SWAP, 6'd5, 6'd6, 16'h0, 1'b0);
        check_eq("swap_done_cyc", done_cyc, 32'd4);
        check_eq("swap_we_cnt", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check_eq("swap_addr0", {26'd0, wr_addr[0]}, 32'd5);
            check_eq("swap_addr1", {26'd0, wr_addr[1]}, 32'd6);
        end
        check_eq("swap_r5", {16'd0, rf_mem[5]}, 32'h00005555);
        check_eq("swap_r6", {16'd0, rf_mem[6]}, 32'h0000AAAA);

        // CLEAR 60..63 ending at the top register
        load(6'd0, 16'hBEEF);
        for (int i = 60; i < 64; i++) load(6'(i), 16'hFFFF);
        issue(OP_CLEAR, 6'd60, 6'd63, 16'h0, 1'b0);
        check_eq("clr_done_cyc", done_cyc, 32'd5);
        check_eq("clr_we_cnt", wr_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) begin
                check_eq("clr_addr", {26'd0, wr_addr[i]}, 32'(60 + i));
                check_eq("clr_data", {16'd0, wr_data[i]}, 32'd0);
            end
            check_eq("clr_mem", {16'd0, rf_mem[60 + i]}, 32'd0);
        end
        check_eq("clr_r0", {16'd0, rf_mem[0]}, 32'h0000BEEF);

        // Empty CLEAR range with CmdValid held high throughout
        issue(OP_CLEAR, 6'd10, 6'd9, 16'h0, 1'b1);
        check_eq("clr_empty_done_cyc", done_cyc, 32'd1);
        check_eq("clr_empty_we_cnt", wr_addr.size(), 32'd0);
        @(negedge clk);
        check_eq("after_done_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("after_done_busy",  {31'd0, busy}, 32'd0);
        check_eq("after_done_pulse", {31'd0, done}, 32'd0);

        // Reset during SWAP WRITE2
        load(6'd5, 16'hAAAA);
        load(6'd6, 16'h5555);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SWAP;
        cmd_reg_a = 6'd5;
        cmd_reg_b = 6'd6;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_read_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        check_eq("rstmid_w1_addr", {26'd0, rf_addr_a}, 32'd5);
        @(negedge clk);
        check_eq("rstmid_w2_we", {31'd0, rf_we}, 32'd1);
        check_eq("rstmid_w2_addr", {26'd0, rf_addr_a}, 32'd6);
        check_eq("rstmid_w2_data", {16'd0, rf_wdata}, 32'h0000AAAA);
        n_reset = 1'b0;
        #1;
        check_eq("rstmid_we", {31'd0, rf_we}, 32'd0);
        check_eq("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        check_eq("rstmid_r5", {16'd0, rf_mem[5]}, 32'h00005555);
        check_eq("rstmid_r6", {16'd0, rf_mem[6]}, 32'h00005555);

        // Sequencer usable again after the interrupted command
        issue(OP_LOAD, 6'd7, 6'd0, 16'h0C0C, 1'b0);
        check_eq("post_rst_done_cyc", done_cyc, 32'd2);
        check_eq("post_rst_r7", {16'd0, rf_mem[7]}, 32'h00000C0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
